// File: rtl/sw_pkg.sv
// Shared switch-path constants, kept common so debounce and PWM blocks agree on widths.
package sw_pkg;

    localparam int unsigned SW_WIDTH_DEF        = 16;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

    // Counter width able to hold 0..cycles without overflow.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return unsigned'($clog2(cycles + 1));
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter and clean-state flop.
module sw_debounce_bit
    import sw_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic clean,
    output logic upd_c
);

    localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sw_meta;
    logic             sw_sync;
    logic [CNT_W-1:0] cnt;

    // The clean value flips once the synchronised input has differed for the full window.
    always_comb begin
        upd_c = (sw_sync != clean) && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= 1'b0;
            sw_sync <= 1'b0;
            cnt     <= '0;
            clean   <= 1'b0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (sw_sync == clean) begin
                cnt <= '0;
            end else if (upd_c) begin
                clean <= sw_sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Debounced switch bank with per-bit edge pulses and an accumulated change event.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int unsigned SW_WIDTH        = SW_WIDTH_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SW_WIDTH-1:0] sw,
    output logic [SW_WIDTH-1:0] sw_clean,
    output logic [SW_WIDTH-1:0] sw_rise,
    output logic [SW_WIDTH-1:0] sw_fall,
    output logic                evt_valid,
    output logic [SW_WIDTH-1:0] evt_mask,
    input  logic                evt_ready
);

    logic [SW_WIDTH-1:0] upd;
    logic                xfer;

    for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk  (clk),
            .rst_n(rst_n),
            .sw   (sw[i]),
            .clean(sw_clean[i]),
            .upd_c(upd[i])
        );
    end

    always_comb begin
        xfer = evt_valid & evt_ready;
    end

    // An updating bit always moves to the opposite of its current clean value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_rise   <= '0;
            sw_fall   <= '0;
            evt_valid <= 1'b0;
            evt_mask  <= '0;
        end else begin
            sw_rise <= upd & ~sw_clean;
            sw_fall <= upd & sw_clean;
            if (xfer) begin
                evt_mask  <= upd;
                evt_valid <= |upd;
            end else begin
                evt_mask  <= evt_mask | upd;
                evt_valid <= evt_valid | (|upd);
            end
        end
    end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-side counterpart of the switch-to-LED output path.
- Samples the asynchronous board switches and synchronises them into the clk domain.
- Filters bounce on each bit, so each clean bit follows its input only after it has been stable for DEBOUNCE_CYCLES cycles.
- Reports per-bit rise/fall pulses, plus an accumulated change event that downstream logic (e.g. sw_pwm, CSR readers) consumes over a valid/ready handshake.

Parameters:
- SW_WIDTH, 16: number of switch inputs.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronised cycles required before a clean bit updates (10 ms at 100 MHz). Must be >= 1. Benches override it to a small value.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous assert, active-low.
- sw  in  SW_WIDTH  raw switch pins, asynchronous to clk.
- sw_clean  out  SW_WIDTH  debounced switch state.
- sw_rise  out  SW_WIDTH  one-cycle pulse when sw_clean[i] goes 0->1.
- sw_fall  out  SW_WIDTH  one-cycle pulse when sw_clean[i] goes 1->0.
- evt_valid  out  1  at least one clean bit has changed since the last accepted event.
- evt_mask  out  SW_WIDTH  bits that changed since the last accepted event.
- evt_ready  in  1  consumer accepts the event.

Behaviour:
- Reset:
  - Interface: one clock (clk); reset rst_n is asynchronous and active-low.
  - While rst_n=0, every register is 0: sync stages, counters, sw_clean, sw_rise, sw_fall, evt_valid, evt_mask.
  - No events are generated for switches that are already high when reset releases; they appear later as rises.
- Synchroniser:
  - Two flops per bit: sw_meta <= sw; sw_sync <= sw_meta. No logic sits between the two stages.
- Per-bit filter, counter width $clog2(DEBOUNCE_CYCLES+1):
  - If sw_sync[i]==sw_clean[i]: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: sw_clean[i]<=sw_sync[i], cnt<=0, upd[i]=1.
  - Else: cnt<=cnt+1.
- Latency: let edge k be the first edge that samples the new sw value. sw_clean changes at edge k+1+DEBOUNCE_CYCLES.
- Glitch rejection: any return to the current clean value before the count completes resets cnt. A pulse shorter than DEBOUNCE_CYCLES cycles never reaches sw_clean.
- Rise/fall pulses:
  - Registered on the same edge as the sw_clean update: sw_rise[i]<=upd[i]&sw_sync[i], sw_fall[i]<=upd[i]&~sw_sync[i].
  - Both are 0 otherwise; they are high for exactly one cycle.
  - Pulses have no backpressure; they are always issued.
- Event handshake:
  - Let chg = upd.
  - Transfer occurs on a cycle with evt_valid & evt_ready.
  - On transfer: evt_mask<=chg, evt_valid<=|chg. Changes in the transfer cycle are not lost.
  - Without transfer: evt_mask<=evt_mask|chg, evt_valid<=evt_valid | (|chg).
  - While evt_valid=1 and no transfer occurs, evt_mask only gains bits; it never drops bits.
  - evt_ready while evt_valid=0 has no effect.
- Simultaneous bit updates: all bits that update on the same edge appear in the same pulse cycle and the same mask.
- Reset mid-count: counters clear; sw_clean returns to 0; pending events are discarded.
- Counter width is sized so it never overflows for any legal DEBOUNCE_CYCLES. DEBOUNCE_CYCLES=1 gives a pure synchroniser plus one compare cycle.

Decomposition:
- Package sw_pkg: SW_WIDTH_DEF=16 and DEBOUNCE_CYCLES_DEF. Shared with sw_pwm for matching widths.
- Sub-module sw_debounce_bit: contains one bit's synchroniser, counter and clean flop, and outputs clean plus upd. It is instantiated SW_WIDTH times via generate.
- Top-level logic: rise/fall registers and the event accumulator/handshake.

Test Plan (DEBOUNCE_CYCLES=4, SW_WIDTH=16):
1. Reset/idle:
   - Stimulus: rst_n low 3 cycles with sw=16'hA5A5, then released.
   - Required: all outputs 0 during reset. sw_clean=16'hA5A5 at edge 6 after release (k+5); sw_rise=16'hA5A5 for 1 cycle; evt_valid=1 with evt_mask=16'hA5A5.
2. Glitch rejection:
   - Stimulus: from clean 0, sw[0] high for 3 cycles, then low.
   - Required: sw_clean stays 0; no pulse; evt_valid stays 0.
3. Clean toggle latency:
   - Stimulus: sw[3] 0->1, held.
   - Required: sw_clean[3]=1 exactly at edge k+5; sw_rise=16'h0008 for one cycle. Releasing to 0 gives sw_fall=16'h0008 with the same latency.
4. Backpressure accumulation:
   - Stimulus: evt_ready=0; toggle bit 1, then later bit 7.
   - Required: evt_mask goes 16'h0002, then 16'h0082; evt_valid held at 1. Asserting evt_ready for one cycle clears evt_valid next cycle.
5. Change during transfer:
   - Stimulus: bit 2 updates on the same cycle as a transfer of mask 16'h0001.
   - Required: next cycle evt_valid=1, evt_mask=16'h0004.
6. Reset mid-count:
   - Stimulus: sw[5] held high; rst_n pulsed low after 2 cycles of counting.
   - Required: after release, sw_clean[5] rises only after the full k+5 latency measured from release.
